pipeline_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage core. Consumes the hazard detector's RAW stall request, the EX-stage branch/JALR redirect and the data-memory busy handshake. Produces per-stage enable/flush controls (stall, bubble, squash, freeze), with performance counters and a stall watchdog. Sits beside the hazard detector in the decode stage; all stage registers take their enables and flushes from this block.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_sat_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and constants for the pipeline sequencer
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // ADDI x0,x0,0 loaded by the IF/ID flush mux
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // consecutive-stall count must hold MAX_STALL up to 255
  localparam int CONSEC_W = 8;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter; clr with inc loads 1
module sat_counter #(
  parameter int           W   = 16,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? W'(1) : '0;
    end else if (inc_i && (cnt_q < MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - 5-stage pipeline sequencer: stall, bubble, squash, freeze, perf counters, watchdog
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_en_o,
  output logic             pc_sel_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             pipe_en_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             stall_timeout_o
);

  localparam logic [2:0]          FL_LOAD   = 3'(FETCH_LAT);
  localparam state_e              RST_STATE = (FETCH_LAT > 0) ? ST_FLUSH : ST_RUN;
  localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MAX_STALL);

  state_e              state_q, state_d;
  logic [2:0]          fl_ctr_q, fl_ctr_d;
  logic                timeout_q, timeout_d;
  logic [CONSEC_W-1:0] consec_cnt;
  logic                redirect, stall_ev, consec_clr, consec_hit;

  // hazard is masked in FLUSH because ID holds a squashed slot
  assign redirect   = !mem_busy_i && branch_taken_i;
  assign stall_ev   = !mem_busy_i && !branch_taken_i && hazard_i && (state_q != ST_FLUSH);
  assign consec_clr = !mem_busy_i && !(state_q == ST_STALL && hazard_i && !branch_taken_i);
  assign consec_hit = (consec_cnt == CONSEC_MAX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RST_STATE;
      fl_ctr_q  <= FL_LOAD;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fl_ctr_q  <= fl_ctr_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fl_ctr_d  = fl_ctr_q;
    timeout_d = timeout_q | consec_hit;
    if (!mem_busy_i) begin
      if (branch_taken_i) begin
        fl_ctr_d = FL_LOAD;
        state_d  = RST_STATE;
      end else if (state_q == ST_FLUSH) begin
        fl_ctr_d = fl_ctr_q - 3'd1;
        if (fl_ctr_q <= 3'd1) state_d = ST_RUN;
      end else begin
        state_d = hazard_i ? ST_STALL : ST_RUN;
      end
    end
  end

  always_comb begin
    pc_en_o      = 1'b0;
    pc_sel_o     = 1'b0;
    ifid_en_o    = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    pipe_en_o    = 1'b0;
    if (rst_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (mem_busy_i) begin
      pipe_en_o = 1'b0;
    end else if (branch_taken_i) begin
      pc_en_o      = 1'b1;
      pc_sel_o     = 1'b1;
      ifid_en_o    = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      pipe_en_o    = 1'b1;
    end else if (state_q == ST_FLUSH) begin
      pc_en_o      = 1'b1;
      ifid_en_o    = 1'b1;
      ifid_flush_o = 1'b1;
      pipe_en_o    = 1'b1;
    end else if (hazard_i) begin
      idex_flush_o = 1'b1;
      pipe_en_o    = 1'b1;
    end else begin
      pc_en_o   = 1'b1;
      ifid_en_o = 1'b1;
      pipe_en_o = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0), .inc_i(stall_ev), .cnt_o(stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(1'b0), .inc_i(redirect), .cnt_o(flush_cnt_o)
  );

  sat_counter #(.W(CONSEC_W), .MAX(CONSEC_MAX)) u_consec_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(consec_clr), .inc_i(stall_ev), .cnt_o(consec_cnt)
  );

  assign state_o         = state_q;
  assign stall_timeout_o = timeout_q | consec_hit;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a behavioural model
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, busy = 1'b0, br = 1'b0, hz = 1'b0;

  logic       pc_en_a, pc_sel_a, ifid_en_a, ifid_flush_a, idex_flush_a, pipe_en_a, to_a;
  logic [1:0] state_a;
  logic [3:0] stall_cnt_a, flush_cnt_a;
  logic       pc_en_b, pc_sel_b, ifid_en_b, ifid_flush_b, idex_flush_b, pipe_en_b, to_b;
  logic [1:0] state_b;
  logic [7:0] stall_cnt_b, flush_cnt_b;
  logic [5:0] ctl_a, ctl_b;

  assign ctl_a = {pc_en_a, pc_sel_a, ifid_en_a, ifid_flush_a, idex_flush_a, pipe_en_a};
  assign ctl_b = {pc_en_b, pc_sel_b, ifid_en_b, ifid_flush_b, idex_flush_b, pipe_en_b};

  pipeline_ctrl #(.FETCH_LAT(1), .MAX_STALL(4), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .hazard_i(hz), .branch_taken_i(br), .mem_busy_i(busy),
    .pc_en_o(pc_en_a), .pc_sel_o(pc_sel_a), .ifid_en_o(ifid_en_a), .ifid_flush_o(ifid_flush_a),
    .idex_flush_o(idex_flush_a), .pipe_en_o(pipe_en_a), .state_o(state_a),
    .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a), .stall_timeout_o(to_a)
  );

  pipeline_ctrl #(.FETCH_LAT(0), .MAX_STALL(1), .CNT_W(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .hazard_i(hz), .branch_taken_i(br), .mem_busy_i(busy),
    .pc_en_o(pc_en_b), .pc_sel_o(pc_sel_b), .ifid_en_o(ifid_en_b), .ifid_flush_o(ifid_flush_b),
    .idex_flush_o(idex_flush_b), .pipe_en_o(pipe_en_b), .state_o(state_b),
    .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b), .stall_timeout_o(to_b)
  );

  typedef struct packed {
    int flush_left;
    bit stalling;
    int consec;
    int stalls;
    int flushes;
    bit timeout;
  } m_t;

  m_t ma, mb;
  bit mvalid = 1'b0;
  int tests = 0, fails = 0;

  function automatic m_t step(m_t m, bit r, bit bz, bit b, bit h, int fl, int mx, int cw);
    m_t n = m;
    int top = (1 << cw) - 1;
    if (r) begin
      n = '0;
      n.flush_left = fl;
    end else if (bz) begin
      n = m;
    end else if (b) begin
      n.flushes    = (m.flushes < top) ? m.flushes + 1 : top;
      n.flush_left = fl;
      n.stalling   = 1'b0;
      n.consec     = 0;
    end else if (m.flush_left > 0) begin
      n.flush_left = m.flush_left - 1;
    end else if (h) begin
      n.stalls   = (m.stalls < top) ? m.stalls + 1 : top;
      n.consec   = m.stalling ? ((m.consec < mx) ? m.consec + 1 : mx) : 1;
      n.stalling = 1'b1;
      if (n.consec == mx) n.timeout = 1'b1;
    end else begin
      n.stalling = 1'b0;
      n.consec   = 0;
    end
    return n;
  endfunction

  // bit order: pc_en, pc_sel, ifid_en, ifid_flush, idex_flush, pipe_en
  function automatic logic [5:0] exp_ctl(m_t m, bit r, bit bz, bit b, bit h);
    if (r)                 return 6'b000110;
    if (bz)                return 6'b000000;
    if (b)                 return 6'b111111;
    if (m.flush_left > 0)  return 6'b101101;
    if (h)                 return 6'b000011;
    return 6'b101001;
  endfunction

  function automatic int exp_state(m_t m);
    if (m.flush_left > 0) return 2;
    return m.stalling ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = step(ma, rst, busy, br, hz, 1, 4, 4);
    mb = step(mb, rst, busy, br, hz, 0, 1, 8);
    if (rst) mvalid = 1'b1;
  end

  // ifid_en is don't-care while IF/ID is being flushed outside reset
  always @(negedge clk) begin
    logic [5:0] ea, eb, mska, mskb;
    ea   = exp_ctl(ma, rst, busy, br, hz);
    eb   = exp_ctl(mb, rst, busy, br, hz);
    mska = (ea[2] && !rst) ? 6'b110111 : 6'b111111;
    mskb = (eb[2] && !rst) ? 6'b110111 : 6'b111111;
    chk("model_ctl_a", int'(ctl_a & mska), int'(ea & mska));
    chk("model_ctl_b", int'(ctl_b & mskb), int'(eb & mskb));
    if (mvalid) begin
      chk("model_state_a", int'(state_a), exp_state(ma));
      chk("model_state_b", int'(state_b), exp_state(mb));
      chk("model_stall_cnt_a", int'(stall_cnt_a), ma.stalls);
      chk("model_stall_cnt_b", int'(stall_cnt_b), mb.stalls);
      chk("model_flush_cnt_a", int'(flush_cnt_a), ma.flushes);
      chk("model_flush_cnt_b", int'(flush_cnt_b), mb.flushes);
      chk("model_timeout_a", int'(to_a), int'(ma.timeout));
      chk("model_timeout_b", int'(to_b), int'(mb.timeout));
    end
  end

  task automatic cyc(input bit r, input bit bz, input bit b, input bit h);
    @(posedge clk);
    #1;
    rst = r; busy = bz; br = b; hz = h;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_ctl_a", int'(ctl_a), 6);
    chk("rst_state_a", int'(state_a), 2);
    chk("rst_state_b", int'(state_b), 0);
    chk("rst_stall_cnt_a", int'(stall_cnt_a), 0);

    cyc(0, 0, 0, 0);
    chk("post_rst1_state_a", int'(state_a), 2);
    chk("post_rst1_ifid_flush_a", int'(ifid_flush_a), 1);
    cyc(0, 0, 0, 0);
    chk("post_rst2_state_a", int'(state_a), 0);
    chk("post_rst2_ctl_a", int'(ctl_a), 6'b101001);

    cyc(0, 0, 0, 1);
    chk("raw1_ctl_a", int'(ctl_a), 6'b000011);
    cyc(0, 0, 0, 1);
    chk("raw2_ctl_a", int'(ctl_a), 6'b000011);
    chk("raw2_state_a", int'(state_a), 1);
    chk("raw2_timeout_b", int'(to_b), 1);
    cyc(0, 0, 0, 0);
    chk("raw_stall_cnt_a", int'(stall_cnt_a), 2);
    chk("raw_timeout_a", int'(to_a), 0);
    cyc(0, 0, 0, 0);
    chk("raw_end_state_a", int'(state_a), 0);

    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("redir_ctl_a", int'(ctl_a & 6'b110111), 6'b110111);
    chk("redir_flush_cnt_before_a", int'(flush_cnt_a), 0);
    cyc(0, 0, 0, 1);
    chk("redir_state_a", int'(state_a), 2);
    chk("redir_masked_pc_en_a", int'(pc_en_a), 1);
    chk("redir_flush_cnt_a", int'(flush_cnt_a), 1);

    cyc(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 0);
      chk("freeze_ctl_a", int'(ctl_a), 0);
      chk("freeze_state_a", int'(state_a), 2);
      chk("freeze_flush_cnt_a", int'(flush_cnt_a), 2);
    end
    cyc(0, 0, 0, 0);
    chk("unfreeze_state_a", int'(state_a), 2);
    chk("unfreeze_ctl_a", int'(ctl_a & 6'b110111), 6'b100101);
    cyc(0, 0, 0, 0);
    chk("unfreeze_done_state_a", int'(state_a), 0);

    for (int k = 1; k <= 5; k++) begin
      cyc(0, 0, 0, 1);
      if (k == 4) chk("wd_before_a", int'(to_a), 0);
      if (k == 5) chk("wd_trip_a", int'(to_a), 1);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("wd_sticky_a", int'(to_a), 1);
    chk("wd_sticky_state_a", int'(state_a), 0);

    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
    end
    chk("sat_stall_cnt_a", int'(stall_cnt_a), 15);
    chk("sat_flush_cnt_a", int'(flush_cnt_a), 2);

    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("rerst_timeout_a", int'(to_a), 0);
    chk("rerst_stall_cnt_a", int'(stall_cnt_a), 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(63) == 0, $urandom_range(5) == 0,
          $urandom_range(7) == 0, $urandom_range(2) == 0);
    end
    cyc(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
